card_payment_responder: RTL and testbench

CARD_PAYMENT_RESPONDER -- requirements
Module: card_payment_responder

---
 rtl/vend_pkg.sv | 16 +
 rtl/card_payment_responder_if.sv | 23 ++
 rtl/pay_timer.sv | 29 ++
 rtl/card_payment_responder.sv | 175 +++++++++++++++++
 tb/tb_card_payment_responder.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// Shared vending/payment definitions: FSM state encoding, COST width and
// the default session spend limit used when PAY_SPEND_LIMIT_EN is defined.
package vend_pkg;

  localparam int COST_W              = 3;
  localparam int SPEND_LIMIT_DEFAULT = 12;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_AUTH_WAIT = 3'd1,
    ST_GRANT     = 3'd2,
    ST_DEBIT     = 3'd3,
    ST_DECLINED  = 3'd4
  } pay_state_t;

endpackage

// File: rtl/card_payment_responder_if.sv
// Vending-controller <-> card payment responder handshake.
// master = vending controller, slave = payment responder.
interface card_payment_responder_if;
  import vend_pkg::*;

  logic [COST_W-1:0] COST;
  logic              VEND;
  logic              FAILED_TRAN;
  logic              INVALID_SEL;
  logic              VALID_TRAN;
  logic              DECLINE;

  modport master (
    output COST, VEND, FAILED_TRAN, INVALID_SEL,
    input  VALID_TRAN, DECLINE
  );

  modport slave (
    input  COST, VEND, FAILED_TRAN, INVALID_SEL,
    output VALID_TRAN, DECLINE
  );

endinterface

// File: rtl/pay_timer.sv
// Loadable down-counter with a done flag. Shared by the authorization
// latency wait and the grant timeout; done is high whenever the count is 0.
module pay_timer #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         done
);

  logic [W-1:0] count_reg;

  // Load has priority over decrement; decrement stops at zero.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_val;
    end else if (dec && (count_reg != '0)) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign done = (count_reg == '0);

endmodule

// File: rtl/card_payment_responder.sv
// Card payment responder: authorizes a vending request against the card
// balance, grants it for a bounded time, and debits on VEND.
// Optional feature macro: PAY_SPEND_LIMIT_EN (per-session spend limit).
// AUTH_WAIT holds AUTH_LATENCY idle cycles followed by one check cycle, so
// VALID_TRAN first rises AUTH_LATENCY+2 cycles after COST becomes non-zero.
module card_payment_responder
  import vend_pkg::*;
#(
  parameter int AUTH_LATENCY  = 1,
  parameter int GRANT_TIMEOUT = 4,
  parameter int BAL_W         = 8
`ifdef PAY_SPEND_LIMIT_EN
  ,
  parameter int SPEND_LIMIT   = SPEND_LIMIT_DEFAULT
`endif
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  CARD_IN,
  input  logic                  LOAD_BAL,
  input  logic [BAL_W-1:0]      BAL_IN,
  output logic [BAL_W-1:0]      BALANCE,
  output logic                  BUSY,
  card_payment_responder_if.slave vc
);

  localparam int TMR_W = 8;
  localparam logic [TMR_W-1:0] AUTH_LOAD  = TMR_W'(AUTH_LATENCY);
  localparam logic [TMR_W-1:0] GRANT_LOAD =
    TMR_W'((GRANT_TIMEOUT > 0) ? (GRANT_TIMEOUT - 1) : 0);

  pay_state_t         state_reg, state_next;
  logic [COST_W-1:0]  cost_q_reg;
  logic [COST_W-1:0]  cost_prev_reg;
  logic               card_reg;
  logic [BAL_W-1:0]   balance_reg;
  logic               valid_tran_reg;
  logic               decline_reg;
  logic               busy_reg;

  logic               cost_edge;
  logic               card_fall;
  logic               auth_ok;
  logic [BAL_W-1:0]   cost_ext;

  logic               timer_load;
  logic [TMR_W-1:0]   timer_val;
  logic               timer_dec;
  logic               timer_done;

  assign cost_edge = (vc.COST != '0) && (cost_prev_reg == '0);
  assign card_fall = card_reg && !CARD_IN;
  assign cost_ext  = BAL_W'(cost_q_reg);

`ifdef PAY_SPEND_LIMIT_EN
  logic [BAL_W:0] spend_reg;
  logic           spend_ok;

  assign spend_ok = ((spend_reg + (BAL_W+1)'(cost_q_reg)) <= (BAL_W+1)'(SPEND_LIMIT));
  assign auth_ok  = CARD_IN && (balance_reg >= cost_ext) && spend_ok;

  // Session spend: accumulates debits, cleared whenever the card is out.
  always_ff @(posedge CLK) begin
    if (RESET || !CARD_IN) begin
      spend_reg <= '0;
    end else if (state_reg == ST_DEBIT) begin
      spend_reg <= spend_reg + (BAL_W+1)'(cost_q_reg);
    end
  end
`else
  assign auth_ok = CARD_IN && (balance_reg >= cost_ext);
`endif

  pay_timer #(.W(TMR_W)) u_timer (
    .CLK      (CLK),
    .RESET    (RESET),
    .load     (timer_load),
    .load_val (timer_val),
    .dec      (timer_dec),
    .done     (timer_done)
  );

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Next-state and timer control.
  always_comb begin
    state_next = state_reg;
    timer_load = 1'b0;
    timer_val  = '0;
    timer_dec  = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (cost_edge) begin
          state_next = ST_AUTH_WAIT;
          timer_load = 1'b1;
          timer_val  = AUTH_LOAD;
        end
      end
      ST_AUTH_WAIT: begin
        if (card_fall) begin
          state_next = ST_IDLE;
        end else if (!timer_done) begin
          timer_dec = 1'b1;
        end else if (auth_ok) begin
          state_next = ST_GRANT;
          timer_load = 1'b1;
          timer_val  = GRANT_LOAD;
        end else begin
          state_next = ST_DECLINED;
        end
      end
      ST_GRANT: begin
        // Card removal wins; VEND wins over FAILED_TRAN/INVALID_SEL.
        if (!CARD_IN) begin
          state_next = ST_IDLE;
        end else if (vc.VEND) begin
          state_next = ST_DEBIT;
        end else if (vc.FAILED_TRAN || vc.INVALID_SEL) begin
          state_next = ST_IDLE;
        end else if (timer_done) begin
          state_next = ST_IDLE;
        end else begin
          timer_dec = 1'b1;
        end
      end
      ST_DEBIT:    state_next = ST_IDLE;
      ST_DECLINED: state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  // Datapath: request capture, edge history, balance load/debit.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cost_q_reg    <= '0;
      cost_prev_reg <= '0;
      card_reg      <= 1'b0;
      balance_reg   <= '0;
    end else begin
      cost_prev_reg <= vc.COST;
      card_reg      <= CARD_IN;
      if ((state_reg == ST_IDLE) && cost_edge) begin
        cost_q_reg <= vc.COST;
      end
      if ((state_reg == ST_IDLE) && LOAD_BAL) begin
        balance_reg <= BAL_IN;
      end else if (state_reg == ST_DEBIT) begin
        balance_reg <= (balance_reg >= cost_ext) ? (balance_reg - cost_ext) : '0;
      end
    end
  end

  // Registered outputs derived from the state being entered.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_tran_reg <= 1'b0;
      decline_reg    <= 1'b0;
      busy_reg       <= 1'b0;
    end else begin
      valid_tran_reg <= (state_next == ST_GRANT);
      decline_reg    <= (state_next == ST_DECLINED);
      busy_reg       <= (state_next != ST_IDLE);
    end
  end

  assign vc.VALID_TRAN = valid_tran_reg;
  assign vc.DECLINE    = decline_reg;
  assign BALANCE       = balance_reg;
  assign BUSY          = busy_reg;

endmodule

// File: tb/tb_card_payment_responder.sv
// Directed bench for card_payment_responder (default parameters).
// Spend-limit steps are included when PAY_SPEND_LIMIT_EN is defined.
module tb_card_payment_responder;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       CARD_IN;
  logic       LOAD_BAL;
  logic [7:0] BAL_IN;
  logic [7:0] BALANCE;
  logic       BUSY;

  int checks = 0;
  int errors = 0;

  card_payment_responder_if vc_if ();

  card_payment_responder dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .CARD_IN  (CARD_IN),
    .LOAD_BAL (LOAD_BAL),
    .BAL_IN   (BAL_IN),
    .BALANCE  (BALANCE),
    .BUSY     (BUSY),
    .vc       (vc_if)
  );

  always #5 CLK = ~CLK;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
    $display("check %-22s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Returns at cycle t+3, where cycle t is the first cycle with COST=c.
  task automatic start_cost(input logic [2:0] c);
    vc_if.COST = 3'd0;
    step();
    vc_if.COST = c;
    step(3);
  endtask

  initial begin
    RESET = 1'b1; CARD_IN = 1'b1; LOAD_BAL = 1'b1; BAL_IN = 8'd99;
    vc_if.COST = 3'd0; vc_if.VEND = 1'b0;
    vc_if.FAILED_TRAN = 1'b0; vc_if.INVALID_SEL = 1'b0;
    step(2);
    chk("rst_balance", BALANCE, 0);
    chk("rst_valid", vc_if.VALID_TRAN, 0);
    chk("rst_decline", vc_if.DECLINE, 0);
    chk("rst_busy", BUSY, 0);
    RESET = 1'b0; BAL_IN = 8'd10;
    step();
    LOAD_BAL = 1'b0;
    chk("load_10", BALANCE, 10);

    // Basic approve + vend: VALID at t+3, VEND at t+4, BALANCE 7 at t+6.
    vc_if.COST = 3'd3;
    step();
    chk("busy_t1", BUSY, 1);
    step();
    chk("valid_t2_low", vc_if.VALID_TRAN, 0);
    step();
    chk("valid_t3", vc_if.VALID_TRAN, 1);
    step();
    chk("valid_t4", vc_if.VALID_TRAN, 1);
    vc_if.VEND = 1'b1;
    step();
    vc_if.VEND = 1'b0;
    chk("valid_debit_low", vc_if.VALID_TRAN, 0);
    step();
    chk("bal_after_vend", BALANCE, 7);
    chk("busy_back_idle", BUSY, 0);
    step(2);
    chk("held_cost_no_retrig", BUSY, 0);

    // Insufficient funds -> one-cycle DECLINE.
    vc_if.COST = 3'd0; LOAD_BAL = 1'b1; BAL_IN = 8'd2;
    step();
    LOAD_BAL = 1'b0;
    start_cost(3'd5);
    chk("decline_pulse", vc_if.DECLINE, 1);
    chk("decline_valid_low", vc_if.VALID_TRAN, 0);
    step();
    chk("decline_one_cycle", vc_if.DECLINE, 0);
    chk("decline_bal", BALANCE, 2);

    // Grant timeout; LOAD_BAL during GRANT ignored.
    LOAD_BAL = 1'b1; BAL_IN = 8'd10;
    step();
    LOAD_BAL = 1'b0;
    start_cost(3'd3);
    chk("to_valid_t3", vc_if.VALID_TRAN, 1);
    step();
    LOAD_BAL = 1'b1; BAL_IN = 8'd55;
    step();
    LOAD_BAL = 1'b0;
    step();
    chk("to_valid_t6", vc_if.VALID_TRAN, 1);
    step();
    chk("to_valid_t7_low", vc_if.VALID_TRAN, 0);
    chk("to_bal", BALANCE, 10);

    // Card pulled during GRANT.
    start_cost(3'd2);
    chk("card_valid", vc_if.VALID_TRAN, 1);
    CARD_IN = 1'b0;
    step();
    chk("card_abort_valid", vc_if.VALID_TRAN, 0);
    chk("card_abort_busy", BUSY, 0);
    CARD_IN = 1'b1;
    step(2);
    chk("card_abort_bal", BALANCE, 10);

    // FAILED_TRAN -> no debit; VEND+FAILED_TRAN -> debit.
    start_cost(3'd4);
    vc_if.FAILED_TRAN = 1'b1;
    step();
    vc_if.FAILED_TRAN = 1'b0;
    chk("failed_valid_low", vc_if.VALID_TRAN, 0);
    step();
    chk("failed_bal", BALANCE, 10);
    start_cost(3'd4);
    vc_if.VEND = 1'b1; vc_if.FAILED_TRAN = 1'b1;
    step();
    vc_if.VEND = 1'b0; vc_if.FAILED_TRAN = 1'b0;
    step();
    chk("vend_fail_bal", BALANCE, 6);

    // Reset during GRANT.
    start_cost(3'd2);
    chk("rst_grant_valid", vc_if.VALID_TRAN, 1);
    RESET = 1'b1;
    step();
    chk("rst_grant_valid_low", vc_if.VALID_TRAN, 0);
    chk("rst_grant_busy", BUSY, 0);
    chk("rst_grant_bal", BALANCE, 0);

    // Load and COST edge in the same cycle; check uses loaded value.
    vc_if.COST = 3'd0;
    step();
    RESET = 1'b0; LOAD_BAL = 1'b1; BAL_IN = 8'd20; vc_if.COST = 3'd6;
    step();
    LOAD_BAL = 1'b0;
    step(2);
    chk("load_cost_valid", vc_if.VALID_TRAN, 1);
    vc_if.VEND = 1'b1;
    step();
    vc_if.VEND = 1'b0;
    step();
    chk("load_cost_bal", BALANCE, 14);

    // Card absent at check -> decline.
    CARD_IN = 1'b0;
    start_cost(3'd1);
    chk("nocard_decline", vc_if.DECLINE, 1);
    chk("nocard_valid_low", vc_if.VALID_TRAN, 0);
    CARD_IN = 1'b1;

`ifdef PAY_SPEND_LIMIT_EN
    step();
    LOAD_BAL = 1'b1; BAL_IN = 8'd50;
    step();
    LOAD_BAL = 1'b0;
    start_cost(3'd6);
    chk("spend1_valid", vc_if.VALID_TRAN, 1);
    vc_if.VEND = 1'b1; step(); vc_if.VEND = 1'b0; step();
    start_cost(3'd6);
    chk("spend2_valid", vc_if.VALID_TRAN, 1);
    vc_if.VEND = 1'b1; step(); vc_if.VEND = 1'b0; step();
    chk("spend_bal", BALANCE, 38);
    start_cost(3'd1);
    chk("spend3_decline", vc_if.DECLINE, 1);
    chk("spend3_valid_low", vc_if.VALID_TRAN, 0);
    CARD_IN = 1'b0;
    step();
    CARD_IN = 1'b1;
    start_cost(3'd1);
    chk("spend_new_session", vc_if.VALID_TRAN, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
